blink_driver: RTL and testbench

Output-side counterpart to the button-press conditioner: it turns single-cycle event pulses into human-visible LED blinks. Each accepted pulse produces one blink: `led` high for exactly `ON_CYCLES` cycles, then low for exactly `GAP_CYCLES` cycles. Pulses that arrive during a blink are queued in a saturating pending counter, so rapid presses show as separate blinks. It sits between event sources (press pulses, score or collision events) and the board LEDR pins.

---
 rtl/blink_driver.sv | 109 ++++++++++
 tb/tb_blink_driver.sv | 93 +++++++++
 2 files changed

// File: rtl/blink_driver.sv
// blink_driver: turns single-cycle event pulses into visible LED blinks.
// Each accepted pulse gives ON_CYCLES of led high followed by GAP_CYCLES low.
// Pulses arriving mid-blink are queued in a saturating pending counter.
module blink_driver #(
    parameter int ON_CYCLES   = 12_500_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int MAX_PENDING = 7,
    localparam int PW         = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pulse,
    output logic          led,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          dropped
);

    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   pending_q, pending_d;
    logic            dropped_q, dropped_d;
    logic            led_q, led_d;
    logic            busy_q, busy_d;

    // Next-state, timer, queue and output decode for the blink sequencer.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        pending_d = pending_q;
        dropped_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                // Event is consumed directly; the queue stays empty.
                if (pulse) state_d = S_ON;
            end
            S_ON: begin
                if (timer_q == ON_LAST) begin
                    state_d = S_GAP;
                    timer_d = '0;
                end
                if (pulse) begin
                    if (pending_q < PEND_MAX) pending_d = pending_q + PW'(1);
                    else                      dropped_d = 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (pending_q != '0 || pulse) state_d = S_ON;
                    else                          state_d = S_IDLE;
                    // A queued blink starts; a simultaneous pulse takes its
                    // place in the queue so the count is unchanged.
                    if (pending_q != '0 && !pulse) pending_d = pending_q - PW'(1);
                end else if (pulse) begin
                    if (pending_q < PEND_MAX) pending_d = pending_q + PW'(1);
                    else                      dropped_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        led_d  = (state_d == S_ON);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            dropped_q <= 1'b0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
        end
    end

    assign led     = led_q;
    assign busy    = busy_q;
    assign pending = pending_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_blink_driver.sv
// Randomized bench for blink_driver against a timestamp-based blink model.
module tb_blink_driver;

    localparam int ON  = 3;
    localparam int GAP = 2;
    localparam int MAXP = 2;
    localparam int PW = $clog2(MAXP + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pulse = 1'b0;
    logic          led, busy, dropped;
    logic [PW-1:0] pending;

    int n_vec = 0;
    int n_err = 0;

    // Model: an active blink is described by the edge it started on.
    bit m_active  = 0;
    int m_start   = 0;
    int m_pending = 0;
    bit m_dropped = 0;
    int cyc = 0;

    blink_driver #(.ON_CYCLES(ON), .GAP_CYCLES(GAP), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(reset), .pulse(pulse),
        .led(led), .busy(busy), .pending(pending), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model by one clock edge given the sampled inputs.
    task automatic model_step(input bit r, input bit p);
        m_dropped = 0;
        if (r) begin
            m_active = 0; m_pending = 0;
        end else if (!m_active) begin
            if (p) begin m_active = 1; m_start = cyc; end
        end else if (cyc == m_start + ON + GAP) begin
            if (m_pending > 0 || p) begin
                m_start = cyc;
                if (m_pending > 0 && !p) m_pending--;
            end else begin
                m_active = 0;
            end
        end else if (p) begin
            if (m_pending < MAXP) m_pending++;
            else m_dropped = 1;
        end
    endtask

    task automatic step(input bit r, input bit p);
        @(negedge clk);
        reset = r; pulse = p;
        @(posedge clk);
        model_step(r, p);
        #1;
        chk("led", int'(led), int'(m_active && cyc < m_start + ON));
        chk("busy", int'(busy), int'(m_active));
        chk("pending", int'(pending), m_pending);
        chk("dropped", int'(dropped), int'(m_dropped));
        cyc++;
    endtask

    initial begin
        int dens;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        // Idle after reset, then directed scenarios.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, (i == 5) || (i == 10));
        for (int i = 0; i < 25; i++) step(1'b0, (i >= 5) && (i <= 8));
        for (int i = 0; i < 10; i++) step(1'b0, (i == 2) || (i == 4));
        step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        // Random phases with varying pulse density and rare resets.
        for (int ph = 0; ph < 24; ph++) begin
            dens = 1 + int'($urandom_range(0, 11));
            for (int i = 0; i < 120; i++)
                step($urandom_range(0, 199) == 0, $urandom_range(0, dens - 1) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
